arp_req_arb: RTL and testbench

Round-robin arbiter that lets `S_COUNT` requesters share the single ARP lookup port (`arp_request_*` / `arp_response_*`) of the ARP module. Typical requesters are the IP TX path and local responders. The block serialises lookups with one transaction in flight. It routes each response back to the requester that issued it and synthesises an error response if the ARP module does not answer within a bounded time.

---
 rtl/arp_req_arb_if.sv | 35 +++
 rtl/arp_req_arb.sv | 143 ++++++++++++++
 tb/tb_arp_req_arb.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_req_arb_if.sv
// Requester-side and ARP-side lookup signals of the ARP request arbiter.
// master is the arbiter's view; slave is the view of the attached requesters/ARP module.
interface arp_req_arb_if #(
    parameter int unsigned S_COUNT = 2
);
    logic [S_COUNT-1:0]    s_arp_request_valid;
    logic [S_COUNT-1:0]    s_arp_request_ready;
    logic [S_COUNT*32-1:0] s_arp_request_ip;
    logic [S_COUNT-1:0]    s_arp_response_valid;
    logic [S_COUNT-1:0]    s_arp_response_ready;
    logic [S_COUNT-1:0]    s_arp_response_error;
    logic [47:0]           s_arp_response_mac;

    logic                  m_arp_request_valid;
    logic                  m_arp_request_ready;
    logic [31:0]           m_arp_request_ip;
    logic                  m_arp_response_valid;
    logic                  m_arp_response_ready;
    logic                  m_arp_response_error;
    logic [47:0]           m_arp_response_mac;

    modport master (
        input  s_arp_request_valid, s_arp_request_ip, s_arp_response_ready,
        input  m_arp_request_ready, m_arp_response_valid, m_arp_response_error, m_arp_response_mac,
        output s_arp_request_ready, s_arp_response_valid, s_arp_response_error, s_arp_response_mac,
        output m_arp_request_valid, m_arp_request_ip, m_arp_response_ready
    );

    modport slave (
        output s_arp_request_valid, s_arp_request_ip, s_arp_response_ready,
        output m_arp_request_ready, m_arp_response_valid, m_arp_response_error, m_arp_response_mac,
        input  s_arp_request_ready, s_arp_response_valid, s_arp_response_error, s_arp_response_mac,
        input  m_arp_request_valid, m_arp_request_ip, m_arp_response_ready
    );
endinterface

// File: rtl/arp_req_arb.sv
// Round-robin arbiter sharing one ARP lookup port among S_COUNT requesters,
// one lookup in flight, with response routing and an optional response timeout.
module arp_req_arb #(
    parameter int unsigned S_COUNT      = 2,
    parameter int unsigned RESP_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    arp_req_arb_if.master      bus,
    output logic               busy,
    output logic [S_COUNT-1:0] grant,
    output logic               timeout_event,
    output logic               stale_drop_event
);
    localparam int unsigned IDX_W = $clog2(S_COUNT);
    localparam int unsigned CNT_W = (RESP_TIMEOUT == 0) ? 1 : $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (RESP_TIMEOUT == 0) ? '0 : CNT_W'(RESP_TIMEOUT - 1);
    localparam bit TO_EN = (RESP_TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   g_q;
    logic [31:0]        ip_q;
    logic [47:0]        mac_q;
    logic [CNT_W-1:0]   cnt;
    logic               req_valid_q;
    logic               rsp_ready_q;
    logic               busy_q;
    logic [S_COUNT-1:0] grant_q;
    logic [S_COUNT-1:0] rsp_valid_q;
    logic [S_COUNT-1:0] rsp_err_q;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [S_COUNT-1:0] sel_onehot;
    logic [31:0]        sel_ip;
    logic               resp_hs_c;
    logic               timeout_hit_c;

    // First valid requester at or above rr_ptr, wrapping modulo S_COUNT.
    always_comb begin : sel_p
        int unsigned idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            idx = 32'(rr_ptr) + 32'(k);
            if (idx >= S_COUNT) idx = idx - S_COUNT;
            if (!sel_found && bus.s_arp_request_valid[IDX_W'(idx)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(idx);
            end
        end
        sel_onehot = sel_found ? (S_COUNT'(1) << sel_idx) : '0;
    end

    always_comb begin
        sel_ip = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (sel_idx == IDX_W'(i)) sel_ip = bus.s_arp_request_ip[i*32 +: 32];
        end
    end

    assign resp_hs_c     = |(rsp_valid_q & bus.s_arp_response_ready);
    // A real response in the last waiting cycle takes precedence over the timeout.
    assign timeout_hit_c = TO_EN && (state == WAIT) && !bus.m_arp_response_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g_q         <= '0;
            ip_q        <= '0;
            mac_q       <= '0;
            cnt         <= '0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            case (state)
                IDLE: if (sel_found) begin
                    state       <= REQ;
                    g_q         <= sel_idx;
                    ip_q        <= sel_ip;
                    grant_q     <= sel_onehot;
                    busy_q      <= 1'b1;
                    req_valid_q <= 1'b1;
                    rsp_ready_q <= 1'b0;
                end
                REQ: if (bus.m_arp_request_ready) begin
                    state       <= WAIT;
                    cnt         <= '0;
                    req_valid_q <= 1'b0;
                    rsp_ready_q <= 1'b1;
                end
                WAIT: begin
                    if (bus.m_arp_response_valid) begin
                        state       <= RESP;
                        mac_q       <= bus.m_arp_response_mac;
                        rsp_valid_q <= grant_q;
                        rsp_err_q   <= grant_q & {S_COUNT{bus.m_arp_response_error}};
                        rsp_ready_q <= 1'b0;
                    end else if (timeout_hit_c) begin
                        state       <= RESP;
                        mac_q       <= '0;
                        rsp_valid_q <= grant_q;
                        rsp_err_q   <= grant_q;
                        rsp_ready_q <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: if (resp_hs_c) begin
                    state       <= IDLE;
                    rr_ptr      <= (g_q == IDX_W'(S_COUNT - 1)) ? '0 : g_q + IDX_W'(1);
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= '0;
                    rsp_err_q   <= '0;
                    rsp_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_arp_request_ready  = (state == IDLE) ? sel_onehot : '0;
    assign bus.s_arp_response_valid = rsp_valid_q;
    assign bus.s_arp_response_error = rsp_err_q;
    assign bus.s_arp_response_mac   = mac_q;
    assign bus.m_arp_request_valid  = req_valid_q;
    assign bus.m_arp_request_ip     = ip_q;
    assign bus.m_arp_response_ready = rsp_ready_q;
    assign busy                     = busy_q;
    assign grant                    = grant_q;
    assign timeout_event            = timeout_hit_c;
    assign stale_drop_event         = (state == IDLE) && bus.m_arp_response_valid;
endmodule

// File: tb/tb_arp_req_arb.sv
// Directed bench for arp_req_arb: transaction-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_arp_req_arb;
    localparam int S  = 2;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arp_req_arb_if #(.S_COUNT(S)) bus();
    logic         busy;
    logic [S-1:0] grant;
    logic         timeout_event;
    logic         stale_drop_event;

    arp_req_arb #(.S_COUNT(S), .RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .grant(grant),
        .timeout_event(timeout_event), .stale_drop_event(stale_drop_event)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bit_of(input logic [S-1:0] v, input int i);
        logic [S-1:0] sh;
        sh = v >> i;
        return sh[0];
    endfunction

    // Round-robin choice: first valid index starting at ptr, wrapping.
    function automatic int pick(input int ptr, input logic [S-1:0] v);
        for (int k = 0; k < S; k++) begin
            if (bit_of(v, (ptr + k) % S)) return (ptr + k) % S;
        end
        return -1;
    endfunction

    // Reference model: who owns the port, whether the lookup was sent/answered.
    int          m_owner = -1;
    int          m_ptr   = 0;
    bit          m_sent  = 1'b0;
    bit          m_have  = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_ip    = '0;
    logic [47:0] m_mac   = '0;
    int          m_hs    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin : model_p
        int p;
        logic [S*32-1:0] ipsh;
        if (!rst_n) begin
            m_owner <= -1; m_ptr <= 0; m_sent <= 1'b0; m_have <= 1'b0;
            m_err <= 1'b0; m_ip <= '0; m_mac <= '0; m_hs <= 0;
        end else if (m_owner < 0) begin
            p = pick(m_ptr, bus.s_arp_request_valid);
            if (p >= 0) begin
                ipsh    = bus.s_arp_request_ip >> (32 * p);
                m_owner <= p;
                m_ip    <= ipsh[31:0];
                m_sent  <= 1'b0;
                m_have  <= 1'b0;
            end
        end else if (!m_sent) begin
            if (bus.m_arp_request_ready) begin
                m_sent <= 1'b1;
                m_hs   <= cyc;
            end
        end else if (!m_have) begin
            if (bus.m_arp_response_valid) begin
                m_have <= 1'b1; m_err <= bus.m_arp_response_error; m_mac <= bus.m_arp_response_mac;
            end else if (cyc - m_hs == TO) begin
                m_have <= 1'b1; m_err <= 1'b1; m_mac <= '0;
            end
        end else if (bit_of(bus.s_arp_response_ready, m_owner)) begin
            m_ptr   <= (m_owner + 1) % S;
            m_owner <= -1;
            m_have  <= 1'b0;
            m_sent  <= 1'b0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin : cmp_p
        logic [S-1:0] e_rr, e_grant, e_rv, e_re;
        bit idle, e_mrv, e_mrr, e_to, e_st;
        int p;
        idle    = (m_owner < 0);
        p       = pick(m_ptr, bus.s_arp_request_valid);
        e_rr    = (idle && p >= 0) ? (S'(1) << p) : '0;
        e_grant = idle ? '0 : (S'(1) << m_owner);
        e_rv    = (!idle && m_have) ? (S'(1) << m_owner) : '0;
        e_re    = (!idle && m_have && m_err) ? (S'(1) << m_owner) : '0;
        e_mrv   = !idle && !m_sent;
        e_mrr   = idle || (m_sent && !m_have);
        e_to    = !idle && m_sent && !m_have && !bus.m_arp_response_valid && (cyc - m_hs == TO);
        e_st    = idle && bus.m_arp_response_valid;
        chk("m_s_req_ready", 64'(bus.s_arp_request_ready), 64'(e_rr));
        chk("m_grant", 64'(grant), 64'(e_grant));
        chk("m_busy", 64'(busy), 64'(!idle));
        chk("m_s_resp_valid", 64'(bus.s_arp_response_valid), 64'(e_rv));
        chk("m_s_resp_error", 64'(bus.s_arp_response_error), 64'(e_re));
        chk("m_m_req_valid", 64'(bus.m_arp_request_valid), 64'(e_mrv));
        chk("m_m_resp_ready", 64'(bus.m_arp_response_ready), 64'(e_mrr));
        chk("m_timeout_event", 64'(timeout_event), 64'(e_to));
        chk("m_stale_event", 64'(stale_drop_event), 64'(e_st));
        if (e_mrv) chk("m_m_req_ip", 64'(bus.m_arp_request_ip), 64'(m_ip));
        if (e_rv != '0) chk("m_s_resp_mac", 64'(bus.s_arp_response_mac), 64'(m_mac));
    end

    // One full lookup with immediate ARP acceptance; returns the granted index.
    task automatic txn(input logic [S-1:0] vld, input logic [47:0] mac, input bit drop, output int g);
        int n;
        bus.s_arp_request_valid = vld;
        #1;
        n = 0;
        while (bus.s_arp_request_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            checks++; failures++;
            $display("FAIL txn_accept: no request_ready within 20 cycles");
        end
        chk("one_hot_ready", 64'($countones(bus.s_arp_request_ready)), 64'd1);
        g = bus.s_arp_request_ready[1] ? 1 : 0;
        tick();
        if (drop) bus.s_arp_request_valid = '0;
        chk("txn_req_valid_n1", 64'(bus.m_arp_request_valid), 64'd1);
        tick();
        bus.m_arp_response_valid = 1'b1;
        bus.m_arp_response_error = 1'b0;
        bus.m_arp_response_mac   = mac;
        tick();
        bus.m_arp_response_valid = 1'b0;
        chk("txn_resp_mac", 64'(bus.s_arp_response_mac), 64'(mac));
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int g;
        int hs;
        int seen;
        int grants[4];
        bus.s_arp_request_valid  = '0;
        bus.s_arp_request_ip     = '0;
        bus.s_arp_response_ready = '1;
        bus.m_arp_request_ready  = 1'b1;
        bus.m_arp_response_valid = 1'b0;
        bus.m_arp_response_error = 1'b0;
        bus.m_arp_response_mac   = '0;

        // Reset values
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_m_resp_ready", 64'(bus.m_arp_response_ready), 64'd1);
        chk("rst_m_req_valid", 64'(bus.m_arp_request_valid), 64'd0);
        chk("rst_m_req_ip", 64'(bus.m_arp_request_ip), 64'd0);
        chk("rst_s_resp_valid", 64'(bus.s_arp_response_valid), 64'd0);
        chk("rst_s_resp_mac", 64'(bus.s_arp_response_mac), 64'd0);
        rst_n = 1'b1;
        tick();

        // Fairness: both requesters hold valid for four transactions
        for (int t = 0; t < 4; t++) begin
            txn(2'b11, 48'h0000_0000_1000 + 48'(t), (t == 3), g);
            grants[t] = g;
        end
        chk("fair_g0", 64'(grants[0]), 64'd0);
        chk("fair_g1", 64'(grants[1]), 64'd1);
        chk("fair_g2", 64'(grants[2]), 64'd0);
        chk("fair_g3", 64'(grants[3]), 64'd1);
        tick();

        // Single request from requester 0, ARP answers after 5 cycles
        bus.s_arp_request_ip[31:0] = 32'hC0A8_0101;
        bus.s_arp_request_valid    = 2'b01;
        #1;
        chk("single_req_ready", 64'(bus.s_arp_request_ready), 64'd1);
        tick();
        bus.s_arp_request_valid = '0;
        chk("single_m_req_valid", 64'(bus.m_arp_request_valid), 64'd1);
        chk("single_m_req_ip", 64'(bus.m_arp_request_ip), 64'hC0A8_0101);
        chk("single_grant_req", 64'(grant), 64'd1);
        tick();
        chk("single_wait_ready", 64'(bus.m_arp_response_ready), 64'd1);
        repeat (4) tick();
        bus.m_arp_response_valid = 1'b1;
        bus.m_arp_response_error = 1'b0;
        bus.m_arp_response_mac   = 48'h0011_2233_4455;
        tick();
        bus.m_arp_response_valid = 1'b0;
        chk("single_s_resp_valid", 64'(bus.s_arp_response_valid), 64'd1);
        chk("single_s_resp_err", 64'(bus.s_arp_response_error), 64'd0);
        chk("single_s_resp_mac", 64'(bus.s_arp_response_mac), 64'h0011_2233_4455);
        chk("single_grant_resp", 64'(grant), 64'd1);
        tick();
        chk("single_idle_grant", 64'(grant), 64'd0);

        // Backpressure: ARP request port stalls for 10 cycles
        bus.m_arp_request_ready     = 1'b0;
        bus.s_arp_request_ip[63:32] = 32'h0A00_0002;
        bus.s_arp_request_valid     = 2'b10;
        #1;
        chk("bp_req_ready", 64'(bus.s_arp_request_ready), 64'd2);
        tick();
        bus.s_arp_request_valid = '0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold_valid", 64'(bus.m_arp_request_valid), 64'd1);
            chk("bp_hold_ip", 64'(bus.m_arp_request_ip), 64'h0A00_0002);
            chk("bp_no_wait", 64'(bus.m_arp_response_ready), 64'd0);
            tick();
        end
        bus.m_arp_request_ready = 1'b1;
        tick();
        chk("bp_wait_ready", 64'(bus.m_arp_response_ready), 64'd1);
        chk("bp_wait_req_low", 64'(bus.m_arp_request_valid), 64'd0);
        bus.m_arp_response_valid = 1'b1;
        bus.m_arp_response_error = 1'b1;
        bus.m_arp_response_mac   = 48'hAABB_CCDD_EEFF;
        tick();
        bus.m_arp_response_valid = 1'b0;
        bus.m_arp_response_error = 1'b0;
        chk("bp_s_resp_valid", 64'(bus.s_arp_response_valid), 64'd2);
        chk("bp_s_resp_err", 64'(bus.s_arp_response_error), 64'd2);
        tick();

        // Timeout: ARP never answers
        bus.s_arp_request_valid = 2'b01;
        tick();
        bus.s_arp_request_valid = '0;
        hs   = cyc;
        seen = -1;
        for (int k = 0; k < 40 && seen < 0; k++) begin
            tick();
            if (timeout_event) seen = cyc;
        end
        if (seen < 0) begin
            checks++; failures++;
            $display("FAIL to_pulse: timeout_event never seen");
        end else begin
            chk("to_delay", 64'(seen - hs), 64'd16);
        end
        tick();
        chk("to_s_resp_valid", 64'(bus.s_arp_response_valid), 64'd1);
        chk("to_s_resp_err", 64'(bus.s_arp_response_error), 64'd1);
        chk("to_s_resp_mac", 64'(bus.s_arp_response_mac), 64'd0);
        chk("to_pulse_gone", 64'(timeout_event), 64'd0);
        tick();

        // Stale response drained in IDLE
        bus.m_arp_response_valid = 1'b1;
        bus.m_arp_response_mac   = 48'h0000_0000_0123;
        #1;
        chk("stale_event", 64'(stale_drop_event), 64'd1);
        chk("stale_ready", 64'(bus.m_arp_response_ready), 64'd1);
        tick();
        bus.m_arp_response_valid = 1'b0;
        #1;
        chk("stale_event_end", 64'(stale_drop_event), 64'd0);
        chk("stale_no_resp", 64'(bus.s_arp_response_valid), 64'd0);
        chk("stale_idle", 64'(busy), 64'd0);

        // Asynchronous reset while waiting on requester 1's lookup
        tick();
        bus.s_arp_request_valid = 2'b10;
        tick();
        bus.s_arp_request_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_grant", 64'(grant), 64'd0);
        chk("mrst_m_resp_ready", 64'(bus.m_arp_response_ready), 64'd1);
        chk("mrst_m_req_valid", 64'(bus.m_arp_request_valid), 64'd0);
        chk("mrst_s_resp_valid", 64'(bus.s_arp_response_valid), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        bus.s_arp_request_valid = 2'b11;
        #1;
        chk("mrst_ptr_zero", 64'(bus.s_arp_request_ready), 64'd1);
        txn(2'b11, 48'h0000_0000_0777, 1'b1, g);
        chk("mrst_grant0", 64'(g), 64'd0);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
